// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for one shared multi-cycle ALU
// Define ALU_ARB_DIVZERO_EN to screen div/mod (sel 0011/0100) by zero before they reach the ALU.
module alu_arbiter #(
  parameter int N       = 4,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req0_sel,
  input  logic [3:0]   req1_sel,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_out,
  input  logic [3:0]   alu_flags,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_data,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t       r_state;
  logic         r_last;
  logic         r_owner;
  logic [3:0]   r_cnt;
  logic [N-1:0] r_alu_a;
  logic [N-1:0] r_alu_b;
  logic [3:0]   r_alu_sel;
  logic [N-1:0] r_rsp_data;
  logic [3:0]   r_rsp_flags;
  logic         r_rsp_err;

  logic         w_idle;
  logic         w_grant0;
  logic         w_grant1;
  logic         w_accept;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic [3:0]   w_sel;
  logic         w_illegal;
  logic         w_divz;
  logic         w_rsp_hs;

  // Requester 1 wins a tie only when requester 0 was granted last.
  assign w_grant1  = req1_valid && (!req0_valid || !r_last);
  assign w_grant0  = req0_valid && !w_grant1;
  assign w_idle    = rst_n && (r_state == S_IDLE);
  assign req0_ready = w_idle && w_grant0;
  assign req1_ready = w_idle && w_grant1;
  assign w_accept  = w_idle && (req0_valid || req1_valid);

  assign w_a       = w_grant1 ? req1_a   : req0_a;
  assign w_b       = w_grant1 ? req1_b   : req0_b;
  assign w_sel     = w_grant1 ? req1_sel : req0_sel;
  assign w_illegal = (w_sel >= 4'd10);

`ifdef ALU_ARB_DIVZERO_EN
  assign w_divz = ((w_sel == 4'd3) || (w_sel == 4'd4)) && (w_b == '0);
`else
  assign w_divz = 1'b0;
`endif

  assign rsp0_valid = rst_n && (r_state == S_RESP) && !r_owner;
  assign rsp1_valid = rst_n && (r_state == S_RESP) &&  r_owner;
  assign w_rsp_hs   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign rsp_data  = r_rsp_data;
  assign rsp_flags = r_rsp_flags;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_cnt       <= 4'd0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= 4'd0;
      r_rsp_data  <= '0;
      r_rsp_flags <= 4'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a   <= w_a;
            r_alu_b   <= w_b;
            r_alu_sel <= w_sel;
            r_owner   <= w_grant1;
            r_last    <= w_grant1;
            // Rejected opcodes never occupy the ALU; their response is ready next cycle.
            if (w_illegal || w_divz) begin
              r_rsp_data  <= '0;
              r_rsp_flags <= w_illegal ? 4'b0000 : 4'b0010;
              r_rsp_err   <= 1'b1;
              r_cnt       <= 4'd0;
              r_state     <= S_RESP;
            end else begin
              r_cnt   <= 4'(ALU_LAT);
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd1) begin
            r_rsp_data  <= alu_out;
            r_rsp_flags <= alu_flags;
            r_rsp_err   <= 1'b0;
            r_cnt       <= 4'd0;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
